// File: rtl/hwpe_tcdm_responder.sv
// Single-bank TCDM target: byte-enabled word array, fixed-latency response
// pipeline and a credit-limited first-word-fall-through response FIFO.
module hwpe_tcdm_responder #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int IW         = 8,
  parameter int NUM_WORDS  = 1024,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            req_i,
  output logic            gnt_o,
  input  logic [AW-1:0]   add_i,
  input  logic            wen_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0]   id_i,
  output logic            r_valid_o,
  input  logic            r_ready_i,
  output logic [DW-1:0]   r_data_o,
  output logic            r_opc_o,
  output logic [IW-1:0]   r_id_o,
  output logic            busy_o
);

  localparam int BW   = DW / 8;
  localparam int OFFW = $clog2(BW);
  localparam int IDXW = $clog2(NUM_WORDS);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic          opc;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } resp_t;

  logic [DW-1:0]   mem [NUM_WORDS];
  logic [CW-1:0]   cnt;
  logic [IDXW-1:0] idx;
  logic            accept;
  logic            acc_valid;
  logic            pop;
  logic            push;
  resp_t           acc_resp;
  resp_t           push_resp;
  logic            unused_addr;

  // Upper address bits and byte-offset bits are deliberately ignored.
  assign idx         = add_i[OFFW +: IDXW];
  assign unused_addr = ^add_i;

  // Grant depends only on the registered credit count, never on a same-cycle pop.
  assign gnt_o     = req_i && (cnt < CW'(FIFO_DEPTH));
  assign accept    = gnt_o;
  assign acc_valid = accept && !clear_i;
  assign pop       = r_valid_o && r_ready_i;

  // NOTE: the read port sees the array before the non-blocking write below
  // lands, so a same-edge read returns old data and the next cycle sees new data.
  assign acc_resp = resp_t'{opc: wen_i, id: id_i, data: wen_i ? mem[idx] : '0};

  // NOTE: the array is a memory, not control state; it gets no reset so it
  // maps onto SRAM and keeps its contents across rst_i and clear_i.
  always_ff @(posedge clk_i) begin
    if (accept && !wen_i) begin
      for (int b = 0; b < BW; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !accept) begin
      cnt <= cnt - 1'b1;
    end
  end

  // LATENCY-1 register stages; the FIFO write itself supplies the final cycle.
  generate
    if (LATENCY > 1) begin : g_pipe
      logic  [LATENCY-2:0] pipe_valid;
      resp_t [LATENCY-2:0] pipe_resp;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_valid <= '0;
          pipe_resp  <= '0;
        end else if (clear_i) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= acc_valid;
          pipe_resp[0]  <= acc_resp;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_resp[i]  <= pipe_resp[i-1];
          end
        end
      end

      assign push      = pipe_valid[LATENCY-2];
      assign push_resp = pipe_resp[LATENCY-2];
    end else begin : g_nopipe
      assign push      = acc_valid;
      assign push_resp = acc_resp;
    end
  endgenerate

  resp_t         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] fifo_cnt;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (clear_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) fifo_mem[wr_ptr] <= push_resp;
  end

  // Outputs are forced to zero when idle so stale storage never leaks out.
  assign r_valid_o = (fifo_cnt != '0);
  assign r_data_o  = r_valid_o ? fifo_mem[rd_ptr].data : '0;
  assign r_opc_o   = r_valid_o ? fifo_mem[rd_ptr].opc  : 1'b0;
  assign r_id_o    = r_valid_o ? fifo_mem[rd_ptr].id   : '0;
  assign busy_o    = (cnt != '0);

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && !clear_i && fifo_cnt == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Bench for hwpe_tcdm_responder: one default instance (LATENCY 1, depth 2)
// and one deep instance (LATENCY 3, depth 4) share the stimulus bus.
module tb_hwpe_tcdm_responder;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int NW = 1024;

  typedef struct packed {
    logic          opc;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    be;
    logic [IW-1:0] id;
    logic [DW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, clear, req, wen, r_ready, sel;
  logic [AW-1:0] add;
  logic [DW-1:0] data;
  logic [3:0]    be;
  logic [IW-1:0] id;

  logic a_req, a_gnt, a_rv, a_opc, a_busy;
  logic b_req, b_gnt, b_rv, b_opc, b_busy;
  logic [DW-1:0] a_rd, b_rd;
  logic [IW-1:0] a_rid, b_rid;

  assign a_req = req & ~sel;
  assign b_req = req & sel;

  hwpe_tcdm_responder #(.DW(DW), .AW(AW), .IW(IW), .NUM_WORDS(NW), .LATENCY(1), .FIFO_DEPTH(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(a_req), .gnt_o(a_gnt),
    .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_valid_o(a_rv), .r_ready_i(r_ready), .r_data_o(a_rd), .r_opc_o(a_opc),
    .r_id_o(a_rid), .busy_o(a_busy));

  hwpe_tcdm_responder #(.DW(DW), .AW(AW), .IW(IW), .NUM_WORDS(NW), .LATENCY(3), .FIFO_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(b_req), .gnt_o(b_gnt),
    .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_valid_o(b_rv), .r_ready_i(r_ready), .r_data_o(b_rd), .r_opc_o(b_opc),
    .r_id_o(b_rid), .busy_o(b_busy));

  always #5 clk = ~clk;

  logic          mg, mv, mo;
  logic [DW-1:0] md;
  logic [IW-1:0] mi;
  assign mg = sel ? b_gnt : a_gnt;
  assign mv = sel ? b_rv  : a_rv;
  assign mo = sel ? b_opc : a_opc;
  assign md = sel ? b_rd  : a_rd;
  assign mi = sel ? b_rid : a_rid;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    acc_cyc = 0;
  bit    rec_en  = 1'b0;
  resp_t sb[$];
  int    vcyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every popped response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mv && r_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", mv, 1'b0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("resp_opc",  mo, e.opc);
        check("resp_id",   mi, e.id);
        check("resp_data", md, e.data);
      end
    end
    if (rec_en && b_rv) vcyc.push_back(cyc);
  end

  task automatic access(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] b, input logic [IW-1:0] i, input logic [DW-1:0] exp);
    bit got;
    got = 1'b0;
    req = 1'b1; wen = rd; add = a; data = d; be = b; id = i;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mg) got = 1'b1;
    end
    if (got) begin
      acc_cyc = cyc;
      sb.push_back(resp_t'{opc: rd, id: i, data: rd ? exp : '0});
    end else begin
      check("gnt_timeout", mg, 1'b1);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    check("drain_empty", sb.size(), 0);
    #1;
  endtask

  vec_t vecs [14];

  initial begin
    int nv;
    int first_g;

    vecs[0]  = '{1'b0, 32'h10,       32'hDEADBEEF, 4'hF, 8'd3,  32'h0};
    vecs[1]  = '{1'b1, 32'h10,       32'h0,        4'h0, 8'd4,  32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h10,       32'h000000AA, 4'h1, 8'd5,  32'h0};
    vecs[3]  = '{1'b1, 32'h10,       32'h0,        4'h0, 8'd6,  32'hDEADBEAA};
    vecs[4]  = '{1'b1, 32'h1010,     32'h0,        4'h0, 8'd7,  32'hDEADBEAA};
    vecs[5]  = '{1'b0, 32'h13,       32'h11223344, 4'h8, 8'd8,  32'h0};
    vecs[6]  = '{1'b1, 32'h11,       32'h0,        4'h0, 8'd9,  32'h11ADBEAA};
    vecs[7]  = '{1'b0, 32'h24,       32'h55555555, 4'hF, 8'd10, 32'h0};
    vecs[8]  = '{1'b0, 32'h24,       32'hFFFFFFFF, 4'h0, 8'd11, 32'h0};
    vecs[9]  = '{1'b1, 32'h24,       32'h0,        4'h0, 8'd12, 32'h55555555};
    vecs[10] = '{1'b1, 32'hFFFF0010, 32'h0,        4'h0, 8'd13, 32'h11ADBEAA};
    vecs[11] = '{1'b0, 32'h28,       32'h0,        4'hF, 8'd14, 32'h0};
    vecs[12] = '{1'b0, 32'h28,       32'hA5A5A5A5, 4'h6, 8'd15, 32'h0};
    vecs[13] = '{1'b1, 32'h28,       32'h0,        4'h0, 8'd16, 32'h00A5A500};

    // Reset state, with a read request pending to show gnt follows req.
    rst = 1'b1; clear = 1'b0; req = 1'b1; wen = 1'b1; add = '0; data = '0;
    be = '0; id = '0; r_ready = 1'b0; sel = 1'b0;
    #12;
    check("rst_rvalid", a_rv,   1'b0);
    check("rst_rdata",  a_rd,   32'h0);
    check("rst_ropc",   a_opc,  1'b0);
    check("rst_rid",    a_rid,  8'h0);
    check("rst_busy",   a_busy, 1'b0);
    check("rst_gnt",    a_gnt,  1'b1);
    req = 1'b0;
    #1;
    check("rst_gnt_idle", a_gnt, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single accesses on the default instance.
    r_ready = 1'b1;
    for (int v = 0; v < 14; v++) begin
      access(vecs[v].rd, vecs[v].addr, vecs[v].data, vecs[v].be, vecs[v].id, vecs[v].exp);
    end
    drain();

    // LATENCY 1: r_valid appears the cycle after the grant cycle.
    check("lat1_idle", a_rv, 1'b0);
    access(1'b1, 32'h10, '0, 4'h0, 8'd40, 32'h11ADBEAA);
    check("lat1_valid", a_rv, 1'b1);
    drain();

    // Credit limit: depth 2 with r_ready low, a third read must wait for a pop.
    @(posedge clk); #1;
    r_ready = 1'b0;
    access(1'b1, 32'h10, '0, 4'h0, 8'd0, 32'h11ADBEAA);
    access(1'b1, 32'h24, '0, 4'h0, 8'd1, 32'h55555555);
    req = 1'b1; wen = 1'b1; add = 32'h28; id = 8'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_no_gnt", a_gnt, 1'b0);
    end
    check("full_busy", a_busy, 1'b1);
    check("full_hold_id", a_rid, 8'd0);
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_no_gnt", a_gnt, 1'b0);
    @(posedge clk); #1;
    r_ready = 1'b0;
    @(negedge clk);
    check("gnt_after_pop", a_gnt, 1'b1);
    sb.push_back(resp_t'{opc: 1'b1, id: 8'd2, data: 32'h00A5A500});
    @(posedge clk); #1;
    req = 1'b0;
    r_ready = 1'b1;
    drain();

    // Clear together with an accepted write: data kept, response dropped.
    @(posedge clk); #1;
    req = 1'b1; wen = 1'b0; add = 32'h20; data = 32'h1234; be = 4'hF; id = 8'd30; clear = 1'b1;
    @(negedge clk);
    check("clear_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    req = 1'b0; clear = 1'b0;
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (a_rv) nv++;
    end
    check("clear_no_resp", nv, 0);
    check("clear_busy", a_busy, 1'b0);
    @(posedge clk); #1;
    access(1'b1, 32'h20, '0, 4'h0, 8'd31, 32'h00001234);
    drain();

    // Deep instance: preload, then an 8-read burst with r_ready held high.
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      access(1'b0, AW'(i * 4), DW'(32'h100 + i), 4'hF, IW'(i), '0);
    end
    drain();
    vcyc.delete();
    rec_en = 1'b1;
    first_g = 0;
    for (int i = 0; i < 8; i++) begin
      access(1'b1, AW'(i * 4), '0, 4'h0, IW'(i), DW'(32'h100 + i));
      if (i == 0) first_g = acc_cyc;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (vcyc.size() >= 8) break;
    end
    check("burst_count", vcyc.size(), 8);
    if (vcyc.size() == 8) begin
      check("burst_first_lat", vcyc[0], first_g + 3);
      check("burst_back2back", vcyc[7], vcyc[0] + 7);
    end
    check("burst_busy_last_pop", b_busy, 1'b1);
    @(negedge clk);
    check("burst_busy_after", b_busy, 1'b0);
    check("burst_rvalid_after", b_rv, 1'b0);
    rec_en = 1'b0;
    drain();

    // Async reset with two responses queued and one still in the pipeline.
    @(posedge clk); #1;
    r_ready = 1'b0;
    access(1'b1, 32'h0, '0, 4'h0, 8'd20, 32'h100);
    access(1'b1, 32'h4, '0, 4'h0, 8'd21, 32'h101);
    access(1'b1, 32'h8, '0, 4'h0, 8'd22, 32'h102);
    @(posedge clk); #1;
    check("prerst_rvalid", b_rv, 1'b1);
    check("prerst_head_id", b_rid, 8'd20);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_rvalid", b_rv, 1'b0);
    check("rst_async_busy", b_busy, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    r_ready = 1'b1;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_rv) nv++;
    end
    check("rst_no_spurious", nv, 0);
    @(posedge clk); #1;
    access(1'b1, 32'h8, '0, 4'h0, 8'd23, 32'h102);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
